cdce62005_spi_responder: RTL
============================

Name: cdce62005_spi_responder

Overview:
- SPI responder (slave side) for the CDCE62005 configuration protocol; it emulates the clock chip's register file.
- Used as an on-board loopback target and as a bench model, so the configuration master and its readback path can be exercised without the part fitted.
- Oversamples spi_clk, spi_le and spi_mosi on the system clock, decodes 32-bit LSB-first frames framed by LE, stores registers 0..8, and answers read commands on spi_miso.

Parameters:
- NUM_REGS, 9, number of implemented registers (addresses 0..NUM_REGS-1).
- SYNC_STAGES, 2, synchronizer depth on spi_clk, spi_le and spi_mosi.

Ports:
- clk  in  1  system clock; must run at 8x spi_clk or faster.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- spi_clk  in  1  gated serial clock from the master; idles low.
- spi_le  in  1  latch enable; low = frame active, rising edge = latch.
- spi_mosi  in  1  serial data in, LSB first, sampled on spi_clk rising.
- spi_miso  out  1  serial data out, LSB first, changes on spi_clk falling.
- dbg_addr  in  4  register select for the local readout port.
- dbg_data  out  28  data field of register dbg_addr (combinational); 0 if dbg_addr >= NUM_REGS.
- frame_valid  out  1  one-clk pulse per accepted 32-bit frame.
- frame_word  out  32  last accepted frame {data[27:0], addr[3:0]}; held between pulses.
- eeprom_cmd  out  1  one-clk pulse on an accepted frame with addr 4'hF.
- frame_err  out  1  one-clk pulse when LE rises after 1..31 or more than 32 bits.

Behaviour:
- Reset values: all registers 28'h0, spi_miso 0, frame_word 0, all pulses 0, bit counter 0, read_pending 0, state IDLE.
- Input path: SYNC_STAGES-flop synchronizers, then a 1-flop delay for edge detection. MOSI is sampled from the same synchronized stage as the detected spi_clk rise.
- FSM states and transitions:
  - IDLE: LE_sync high. A falling edge of LE goes to SHIFT, clears the bit counter and, if read_pending, loads the output shifter.
  - SHIFT: each spi_clk rise shifts MOSI into rx[31] (right shift) and increments the counter, which saturates at 33. A rising edge of LE goes to COMMIT.
  - COMMIT: one clock, then IDLE.
- COMMIT with count == 32, normal frame:
  - frame_word <= rx; frame_valid pulses; addr = rx[3:0].
  - addr < NUM_REGS: reg[addr] <= rx[31:4].
  - addr 4'hE: read command; sets read_pending, rd_addr = rx[7:4].
  - addr 4'hF: eeprom_cmd pulses; registers unchanged.
  - addr between NUM_REGS and 4'hD: frame_valid pulses, no storage.
- COMMIT with count == 32 during a readback frame: MOSI content is discarded, no frame_valid, read_pending clears.
- COMMIT with count 1..31 or 33: frame_err pulses, nothing stored, read_pending is kept.
- COMMIT with count == 0 (LE toggled with no clocks): silent, no pulse.
- Readback frame (read_pending set at LE fall):
  - Output shifter loads {reg[rd_addr], rd_addr}, or {28'h0, rd_addr} if rd_addr >= NUM_REGS.
  - spi_miso presents bit 0 before the first spi_clk rise.
  - Each spi_clk fall shifts right; spi_miso follows bit 0.
  - After 32 bits, or outside a readback frame, spi_miso = 0.
- Latency: frame_valid, eeprom_cmd and frame_err assert SYNC_STAGES+2 clk after the spi_le pin rise.
- Simultaneous events:
  - spi_clk rise detected in the same clk as the LE rise: the clock edge is ignored and the LE rise wins.
  - spi_clk edges while LE_sync is high are ignored.
- Back-to-back frames need LE high for at least 1 sync'd clk; a shorter LE pulse is filtered by the synchronizer and the frame continues with its count.
- rst_n low mid-frame: immediate return to the reset state, partial frame lost, read_pending cleared. The next frame needs a fresh LE fall.
- dbg_data never reflects a partial frame; registers update only in COMMIT.

Test Plan:
- Write 0x81400320, then 0x81400321 -> reg0 = 0x8140032, then reg1 = 0x8140032; frame_valid pulses twice; frame_word = 0x81400321; no frame_err.
- Write 0x0000008E (read reg 8) after reg8 = 0x8000180, then a 32-clock readback frame with MOSI = 1 -> master samples 0x80001808 LSB first; reg8 unchanged; no frame_valid on the second frame.
- Write 0x0000001F -> eeprom_cmd pulses once; reg0..reg8 unchanged; frame_word = 0x0000001F.
- LE low with 20 clocks, then LE high -> frame_err pulse; registers unchanged. Then a 34-clock frame -> frame_err again.
- Assert rst_n low after 16 bits of a write to reg5 -> reg5 = 0, spi_miso = 0. The following full write of 0x90000EB5 succeeds: reg5 = 0x90000EB.
- Read command 0x000000AE (addr 10) -> readback frame returns 0x0000000A; dbg_addr = 10 gives dbg_data = 0.

Source files
------------

// File: rtl/cdce62005_spi_responder_if.sv
// Serial configuration bus between a CDCE62005 configuration master and the
// responder that emulates the clock chip. The master drives clock, latch
// enable and data; the responder drives readback data.
interface cdce62005_spi_responder_if;
    logic spi_clk;
    logic spi_le;
    logic spi_mosi;
    logic spi_miso;

    modport master (
        output spi_clk,
        output spi_le,
        output spi_mosi,
        input  spi_miso
    );

    modport slave (
        input  spi_clk,
        input  spi_le,
        input  spi_mosi,
        output spi_miso
    );
endinterface

// File: rtl/cdce62005_spi_responder.sv
// CDCE62005 register-file emulator on the serial configuration bus.
// All bus pins are oversampled on clk. 32-bit LSB-first frames are framed by
// LE and committed on its rising edge. Address 4'hE arms a readback that is
// returned on spi_miso during the following frame.
module cdce62005_spi_responder #(
    parameter int NUM_REGS    = 9,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    cdce62005_spi_responder_if.slave   spi,
    input  logic [3:0]                 dbg_addr,
    output logic [27:0]                dbg_data,
    output logic                       frame_valid,
    output logic [31:0]                frame_word,
    output logic                       eeprom_cmd,
    output logic                       frame_err
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    localparam logic [4:0] NREG = 5'(NUM_REGS);

    state_t state, next_state;

    logic [SYNC_STAGES-1:0] clk_sync, le_sync, mosi_sync;
    logic        clk_dly, le_dly;
    logic        sclk_s, le_s, mosi_s;
    logic        sclk_rise, sclk_fall, le_rise, le_fall;

    logic [31:0] rx;
    logic [5:0]  bit_cnt;
    logic [27:0] regs [NUM_REGS];
    logic        read_pending;
    logic [3:0]  rd_addr;
    logic        rb_frame;
    logic [31:0] tx_shift;
    logic [31:0] tx_load;
    logic        tx_active;
    logic [4:0]  tx_cnt;

    assign sclk_s    = clk_sync[SYNC_STAGES-1];
    assign le_s      = le_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~clk_dly;
    assign sclk_fall = ~sclk_s & clk_dly;
    assign le_rise   = le_s & ~le_dly;
    assign le_fall   = ~le_s & le_dly;

    assign spi.spi_miso = tx_active & tx_shift[0];

    // Bring the asynchronous bus pins into the clk domain and keep one extra
    // stage of clock and LE history for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= '0;
            le_sync   <= '0;
            mosi_sync <= '0;
            clk_dly   <= 1'b0;
            le_dly    <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], spi.spi_clk};
            le_sync   <= {le_sync[SYNC_STAGES-2:0], spi.spi_le};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.spi_mosi};
            clk_dly   <= sclk_s;
            le_dly    <= le_s;
        end
    end

    // Frame state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Frame sequencing: LE fall opens a frame, LE rise closes it.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (le_fall) next_state = SHIFT;
            SHIFT:   if (le_rise) next_state = COMMIT;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Readback word for the armed address; unimplemented addresses read zero.
    always_comb begin
        tx_load = {28'h0, rd_addr};
        if ({1'b0, rd_addr} < NREG) tx_load = {regs[rd_addr], rd_addr};
    end

    // Local readout of one register's data field.
    always_comb begin
        dbg_data = 28'h0;
        if ({1'b0, dbg_addr} < NREG) dbg_data = regs[dbg_addr];
    end

    // Shift, readback and commit datapath; registers only change in COMMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx           <= '0;
            bit_cnt      <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            frame_word   <= '0;
            frame_valid  <= 1'b0;
            eeprom_cmd   <= 1'b0;
            frame_err    <= 1'b0;
            read_pending <= 1'b0;
            rd_addr      <= '0;
            rb_frame     <= 1'b0;
            tx_shift     <= '0;
            tx_active    <= 1'b0;
            tx_cnt       <= '0;
        end else begin
            frame_valid <= 1'b0;
            eeprom_cmd  <= 1'b0;
            frame_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (le_fall) begin
                        bit_cnt  <= '0;
                        rb_frame <= read_pending;
                        if (read_pending) begin
                            tx_shift  <= tx_load;
                            tx_active <= 1'b1;
                            tx_cnt    <= '0;
                        end
                    end
                end
                SHIFT: begin
                    if (!le_rise) begin
                        if (sclk_rise) begin
                            rx <= {mosi_s, rx[31:1]};
                            if (bit_cnt != 6'd33) bit_cnt <= bit_cnt + 6'd1;
                        end
                        if (sclk_fall && tx_active) begin
                            tx_shift <= {1'b0, tx_shift[31:1]};
                            tx_cnt   <= tx_cnt + 5'd1;
                            if (tx_cnt == 5'd31) tx_active <= 1'b0;
                        end
                    end
                end
                COMMIT: begin
                    tx_active <= 1'b0;
                    rb_frame  <= 1'b0;
                    if (bit_cnt == 6'd32) begin
                        if (rb_frame) begin
                            read_pending <= 1'b0;
                        end else begin
                            frame_word  <= rx;
                            frame_valid <= 1'b1;
                            if (rx[3:0] == 4'hE) begin
                                read_pending <= 1'b1;
                                rd_addr      <= rx[7:4];
                            end else if (rx[3:0] == 4'hF) begin
                                eeprom_cmd <= 1'b1;
                            end else if ({1'b0, rx[3:0]} < NREG) begin
                                regs[rx[3:0]] <= rx[31:4];
                            end
                        end
                    end else if (bit_cnt != 6'd0) begin
                        frame_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
